// File: rtl/mem_bus_arbiter_if.sv
// Request/response channel between one bus master and the arbiter.
// A master drives valid/addr/wdata/wmask/lock and holds them stable until
// ready. It receives a one-cycle rvalid pulse carrying rdata for each
// accepted read.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32
) ();

  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        wmask;
  logic              lock;
  logic              ready;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (
    output valid, addr, wdata, wmask, lock,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, addr, wdata, wmask, lock,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter in front of the single-ported SOC memory.
// Master 0 (CPU) and master 1 (DMA / loader) share the memory bus.
// A beat is issued to memory in the same cycle it is accepted.
// Reads return one cycle later on the accepting master's rvalid.
// A master may lock the bus for a burst. The lock is bounded to MAX_LOCK
// cycles (1..255); after that the other master gets the next turn.
module mem_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int FIXED_PRIO = 0,
  parameter int MAX_LOCK   = 8
) (
  input  logic              clk,
  input  logic              resetn,
  mem_bus_arbiter_if.slave  m0,
  mem_bus_arbiter_if.slave  m1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  output logic              mem_rstrb,
  input  logic [31:0]       mem_rdata
);

  logic       last_grant_q, last_grant_d;
  logic       locked_q,     locked_d;
  logic       lock_owner_q, lock_owner_d;
  logic [7:0] lock_cnt_q,   lock_cnt_d;
  logic       rd_pend_q,    rd_pend_d;
  logic       rd_owner_q,   rd_owner_d;
  // Set for one cycle after m0 was forced off the bus, so that fixed
  // priority does not hand the bus straight back to m0.
  logic       fixed_skip_q, fixed_skip_d;

  logic       grant0;
  logic       grant1;
  logic       owner_lock;
  logic       hold;
  logic       forced;
  logic       accept;
  logic       acc_lock;
  logic [3:0] sel_wmask;

  // Grant selection: an active lock wins; otherwise use single-requester,
  // fixed-priority or round-robin arbitration.
  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    owner_lock = lock_owner_q ? m1.lock : m0.lock;
    hold       = locked_q & owner_lock;
    if (hold) begin
      if (lock_owner_q) begin
        grant1 = m1.valid;
      end else begin
        grant0 = m0.valid;
      end
    end else if (m0.valid && !m1.valid) begin
      grant0 = 1'b1;
    end else if (m1.valid && !m0.valid) begin
      grant1 = 1'b1;
    end else if (m0.valid && m1.valid) begin
      if (FIXED_PRIO != 0) begin
        if (fixed_skip_q) begin
          grant1 = 1'b1;
        end else begin
          grant0 = 1'b1;
        end
      end else if (last_grant_q) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
    end
  end

  assign forced    = hold & (lock_cnt_q == 8'(MAX_LOCK));
  assign accept    = grant0 | grant1;
  assign acc_lock  = grant1 ? m1.lock : m0.lock;
  assign sel_wmask = grant1 ? m1.wmask : m0.wmask;

  assign m0.ready  = grant0 & m0.valid;
  assign m1.ready  = grant1 & m1.valid;

  // The bus carries the granted master's address and data. When idle it
  // carries m0's, so the address lines only toggle for m1 when m1 is granted.
  assign mem_addr  = grant1 ? m1.addr  : m0.addr;
  assign mem_wdata = grant1 ? m1.wdata : m0.wdata;
  assign mem_wmask = accept ? sel_wmask : 4'h0;
  assign mem_rstrb = accept & (sel_wmask == 4'h0);

  assign m0.rvalid = rd_pend_q & ~rd_owner_q;
  assign m1.rvalid = rd_pend_q &  rd_owner_q;
  assign m0.rdata  = mem_rdata;
  assign m1.rdata  = mem_rdata;

  // Next-state computation for the fairness pointer, the lock, and the
  // read-response pipeline.
  always_comb begin
    last_grant_d = last_grant_q;
    locked_d     = locked_q;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = lock_cnt_q;
    rd_pend_d    = mem_rstrb;
    rd_owner_d   = rd_owner_q;
    fixed_skip_d = 1'b0;

    if (accept) begin
      last_grant_d = grant1;
    end
    if (mem_rstrb) begin
      rd_owner_d = grant1;
    end

    if (hold) begin
      if (forced) begin
        // Time is up. The owner may finish this beat but cannot re-lock,
        // and it is recorded as the last grant so the other master wins next.
        locked_d     = 1'b0;
        lock_cnt_d   = 8'd0;
        last_grant_d = lock_owner_q;
        fixed_skip_d = ~lock_owner_q;
      end else begin
        lock_cnt_d = lock_cnt_q + 8'd1;
      end
    end else begin
      // Unlocked, or the owner dropped its lock this cycle. A newly accepted
      // beat carrying lock starts a fresh lock.
      locked_d   = 1'b0;
      lock_cnt_d = 8'd0;
      if (accept && acc_lock) begin
        locked_d     = 1'b1;
        lock_owner_d = grant1;
        lock_cnt_d   = 8'd1;
      end
    end
  end

  // State registers with synchronous active-low reset. Reset drops any
  // pending read response and any lock.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_grant_q <= 1'b1;
      locked_q     <= 1'b0;
      lock_owner_q <= 1'b0;
      lock_cnt_q   <= 8'd0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
      fixed_skip_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      locked_q     <= locked_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
      fixed_skip_q <= fixed_skip_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter.
// Two instances share one set of master stimulus: a round-robin arbiter
// and a fixed-priority arbiter, both with MAX_LOCK=4. Each instance has a
// small memory model that returns a known data pattern for every address.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic        m0_valid = 1'b0, m0_lock = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic [3:0]  m0_wmask = '0;
  logic        m1_valid = 1'b0, m1_lock = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m1_wmask = '0;

  logic [31:0] rr_mem_addr, rr_mem_wdata, fp_mem_addr, fp_mem_wdata;
  logic [3:0]  rr_mem_wmask, fp_mem_wmask;
  logic        rr_mem_rstrb, fp_mem_rstrb;
  logic [31:0] rr_mem_rdata = '0, fp_mem_rdata = '0;

  mem_bus_arbiter_if #(.ADDR_W(32)) rr_m0 ();
  mem_bus_arbiter_if #(.ADDR_W(32)) rr_m1 ();
  mem_bus_arbiter_if #(.ADDR_W(32)) fp_m0 ();
  mem_bus_arbiter_if #(.ADDR_W(32)) fp_m1 ();

  assign rr_m0.valid = m0_valid; assign rr_m0.addr = m0_addr; assign rr_m0.wdata = m0_wdata;
  assign rr_m0.wmask = m0_wmask; assign rr_m0.lock = m0_lock;
  assign rr_m1.valid = m1_valid; assign rr_m1.addr = m1_addr; assign rr_m1.wdata = m1_wdata;
  assign rr_m1.wmask = m1_wmask; assign rr_m1.lock = m1_lock;
  assign fp_m0.valid = m0_valid; assign fp_m0.addr = m0_addr; assign fp_m0.wdata = m0_wdata;
  assign fp_m0.wmask = m0_wmask; assign fp_m0.lock = m0_lock;
  assign fp_m1.valid = m1_valid; assign fp_m1.addr = m1_addr; assign fp_m1.wdata = m1_wdata;
  assign fp_m1.wmask = m1_wmask; assign fp_m1.lock = m1_lock;

  mem_bus_arbiter #(.ADDR_W(32), .FIXED_PRIO(0), .MAX_LOCK(4)) dut_rr (
    .clk(clk), .resetn(resetn), .m0(rr_m0), .m1(rr_m1),
    .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata), .mem_wmask(rr_mem_wmask),
    .mem_rstrb(rr_mem_rstrb), .mem_rdata(rr_mem_rdata)
  );

  mem_bus_arbiter #(.ADDR_W(32), .FIXED_PRIO(1), .MAX_LOCK(4)) dut_fp (
    .clk(clk), .resetn(resetn), .m0(fp_m0), .m1(fp_m1),
    .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_wmask(fp_mem_wmask),
    .mem_rstrb(fp_mem_rstrb), .mem_rdata(fp_mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  // Registered-read memory models: data appears the cycle after rstrb.
  always @(posedge clk) begin
    if (rr_mem_rstrb) rr_mem_rdata <= mem_val(rr_mem_addr);
    if (fp_mem_rstrb) fp_mem_rdata <= mem_val(fp_mem_addr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_valid = 1'b0; m0_lock = 1'b0; m0_wmask = 4'h0; m0_addr = '0; m0_wdata = '0;
    m1_valid = 1'b0; m1_lock = 1'b0; m1_wmask = 4'h0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    step();
    step();
    #1;
    checks++; if (rr_m0.rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m0_rvalid: got %b expected 0", rr_m0.rvalid); end
    checks++; if (rr_m1.rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m1_rvalid: got %b expected 0", rr_m1.rvalid); end
    checks++; if (rr_m0.ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_m0_ready: got %b expected 0", rr_m0.ready); end
    checks++; if (rr_m1.ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_m1_ready: got %b expected 0", rr_m1.ready); end
    checks++; if (rr_mem_rstrb !== 1'b0) begin errors++; $display("[TB] FAIL reset_rstrb: got %b expected 0", rr_mem_rstrb); end
    checks++; if (rr_mem_wmask !== 4'h0) begin errors++; $display("[TB] FAIL reset_wmask: got %h expected 0", rr_mem_wmask); end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_single_master();
    // Cycle A: m0 reads 0x10.
    m0_valid = 1'b1; m0_addr = 32'h10; m0_wmask = 4'h0;
    #1;
    checks++; if (rr_m0.ready !== 1'b1) begin errors++; $display("[TB] FAIL single_rd_ready: got %b expected 1", rr_m0.ready); end
    checks++; if (rr_mem_rstrb !== 1'b1) begin errors++; $display("[TB] FAIL single_rd_rstrb: got %b expected 1", rr_mem_rstrb); end
    checks++; if (rr_mem_addr !== 32'h10) begin errors++; $display("[TB] FAIL single_rd_addr: got %h expected 10", rr_mem_addr); end
    checks++; if (rr_mem_wmask !== 4'h0) begin errors++; $display("[TB] FAIL single_rd_wmask: got %h expected 0", rr_mem_wmask); end
    checks++; if (rr_m1.rvalid !== 1'b0) begin errors++; $display("[TB] FAIL single_rd_m1_rvalid: got %b expected 0", rr_m1.rvalid); end
    step();
    // Cycle B: m0 writes 0xDEADBEEF to 0x14; the read response arrives.
    m0_addr = 32'h14; m0_wmask = 4'hF; m0_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (rr_m0.ready !== 1'b1) begin errors++; $display("[TB] FAIL single_wr_ready: got %b expected 1", rr_m0.ready); end
    checks++; if (rr_mem_rstrb !== 1'b0) begin errors++; $display("[TB] FAIL single_wr_rstrb: got %b expected 0", rr_mem_rstrb); end
    checks++; if (rr_mem_wmask !== 4'hF) begin errors++; $display("[TB] FAIL single_wr_wmask: got %h expected f", rr_mem_wmask); end
    checks++; if (rr_mem_wdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_wr_wdata: got %h expected deadbeef", rr_mem_wdata); end
    checks++; if (rr_m0.rvalid !== 1'b1) begin errors++; $display("[TB] FAIL single_rd_rvalid: got %b expected 1", rr_m0.rvalid); end
    checks++; if (rr_m0.rdata !== mem_val(32'h10)) begin errors++; $display("[TB] FAIL single_rd_rdata: got %h expected %h", rr_m0.rdata, mem_val(32'h10)); end
    checks++; if (rr_m1.rvalid !== 1'b0) begin errors++; $display("[TB] FAIL single_wr_m1_rvalid: got %b expected 0", rr_m1.rvalid); end
    step();
    // Cycle C: idle; the write produces no response.
    idle_inputs();
    #1;
    checks++; if (rr_m0.rvalid !== 1'b0) begin errors++; $display("[TB] FAIL single_wr_no_resp: got %b expected 0", rr_m0.rvalid); end
    checks++; if (rr_m0.ready !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_ready: got %b expected 0", rr_m0.ready); end
    step();
  endtask

  task automatic test_round_robin();
    logic [31:0] a0, a1, last_addr, got_rdata;
    logic        exp0, exp1, last_w, got_rv0, got_rv1;
    int          w;
    do_reset();
    a0 = 32'h100; a1 = 32'h200; last_w = 1'b0; last_addr = '0;
    m0_valid = 1'b1; m1_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      m0_addr = a0; m1_addr = a1;
      if (i == 6) begin m0_valid = 1'b0; m1_valid = 1'b0; end
      #1;
      w = i % 2;
      exp0 = (w == 0); exp1 = (w == 1);
      if (i < 6) begin
        checks++; if (rr_m0.ready !== exp0) begin errors++; $display("[TB] FAIL rr_m0_ready[%0d]: got %b expected %b", i, rr_m0.ready, exp0); end
        checks++; if (rr_m1.ready !== exp1) begin errors++; $display("[TB] FAIL rr_m1_ready[%0d]: got %b expected %b", i, rr_m1.ready, exp1); end
        checks++; if (rr_mem_addr !== (exp1 ? a1 : a0)) begin errors++; $display("[TB] FAIL rr_addr[%0d]: got %h expected %h", i, rr_mem_addr, exp1 ? a1 : a0); end
      end
      if (i > 0) begin
        got_rv0 = rr_m0.rvalid; got_rv1 = rr_m1.rvalid;
        got_rdata = last_w ? rr_m1.rdata : rr_m0.rdata;
        checks++; if (got_rv0 !== ~last_w) begin errors++; $display("[TB] FAIL rr_m0_rvalid[%0d]: got %b expected %b", i, got_rv0, ~last_w); end
        checks++; if (got_rv1 !== last_w) begin errors++; $display("[TB] FAIL rr_m1_rvalid[%0d]: got %b expected %b", i, got_rv1, last_w); end
        checks++; if (got_rdata !== mem_val(last_addr)) begin errors++; $display("[TB] FAIL rr_rdata[%0d]: got %h expected %h", i, got_rdata, mem_val(last_addr)); end
      end
      if (i < 6) begin
        last_w = exp1;
        last_addr = exp1 ? a1 : a0;
        if (exp1) a1 = a1 + 32'd4; else a0 = a0 + 32'd4;
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_fixed_priority();
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h800;
    m1_valid = 1'b1; m1_addr = 32'h900;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) m0_valid = 1'b0;
      #1;
      checks++; if (fp_m0.ready !== (i < 4)) begin errors++; $display("[TB] FAIL fp_m0_ready[%0d]: got %b expected %b", i, fp_m0.ready, i < 4); end
      checks++; if (fp_m1.ready !== (i == 4)) begin errors++; $display("[TB] FAIL fp_m1_ready[%0d]: got %b expected %b", i, fp_m1.ready, i == 4); end
      step();
      m0_addr = m0_addr + 32'd4;
    end
    idle_inputs();
    step();
  endtask

  task automatic test_fixed_forced_release();
    // m0 locks with m1 waiting: acquire beat plus 4 locked cycles, then m1
    // gets exactly one turn before fixed priority returns to m0.
    do_reset();
    m0_valid = 1'b1; m0_lock = 1'b1; m0_wmask = 4'hF; m0_addr = 32'hA00;
    m1_valid = 1'b1; m1_wmask = 4'hF; m1_addr = 32'hB00;
    for (int i = 0; i < 7; i++) begin
      #1;
      checks++; if (fp_m0.ready !== (i != 5)) begin errors++; $display("[TB] FAIL fpl_m0_ready[%0d]: got %b expected %b", i, fp_m0.ready, i != 5); end
      checks++; if (fp_m1.ready !== (i == 5)) begin errors++; $display("[TB] FAIL fpl_m1_ready[%0d]: got %b expected %b", i, fp_m1.ready, i == 5); end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_lock_bound();
    // m1 acquires alone in cycle 0, holds the lock for 4 cycles against m0,
    // is forced off, m0 takes cycle 5, then m1 re-acquires in cycle 6.
    do_reset();
    m1_valid = 1'b1; m1_lock = 1'b1; m1_wmask = 4'hF; m1_addr = 32'h400;
    m0_wmask = 4'hF; m0_addr = 32'h480;
    for (int i = 0; i < 7; i++) begin
      m0_valid = (i > 0);
      #1;
      checks++; if (rr_m1.ready !== (i != 5)) begin errors++; $display("[TB] FAIL lock_m1_ready[%0d]: got %b expected %b", i, rr_m1.ready, i != 5); end
      checks++; if (rr_m0.ready !== (i == 5)) begin errors++; $display("[TB] FAIL lock_m0_ready[%0d]: got %b expected %b", i, rr_m0.ready, i == 5); end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_voluntary_release();
    do_reset();
    // m0 acquires with a read.
    m0_valid = 1'b1; m0_lock = 1'b1; m0_addr = 32'h500;
    #1;
    checks++; if (rr_m0.ready !== 1'b1) begin errors++; $display("[TB] FAIL vol_acquire: got %b expected 1", rr_m0.ready); end
    step();
    // m0 idles holding lock; m1 must stay blocked.
    m0_valid = 1'b0; m1_valid = 1'b1; m1_addr = 32'h600;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (rr_m1.ready !== 1'b0) begin errors++; $display("[TB] FAIL vol_blocked[%0d]: got %b expected 0", i, rr_m1.ready); end
      checks++; if (rr_mem_rstrb !== 1'b0) begin errors++; $display("[TB] FAIL vol_rstrb[%0d]: got %b expected 0", i, rr_mem_rstrb); end
      if (i == 0) begin
        checks++; if (rr_m0.rvalid !== 1'b1) begin errors++; $display("[TB] FAIL vol_m0_rvalid: got %b expected 1", rr_m0.rvalid); end
        checks++; if (rr_m0.rdata !== mem_val(32'h500)) begin errors++; $display("[TB] FAIL vol_m0_rdata: got %h expected %h", rr_m0.rdata, mem_val(32'h500)); end
      end
      step();
    end
    // m0 drops lock: m1 accepted in the same cycle.
    m0_lock = 1'b0;
    #1;
    checks++; if (rr_m1.ready !== 1'b1) begin errors++; $display("[TB] FAIL vol_release_ready: got %b expected 1", rr_m1.ready); end
    checks++; if (rr_mem_addr !== 32'h600) begin errors++; $display("[TB] FAIL vol_release_addr: got %h expected 600", rr_mem_addr); end
    step();
    idle_inputs();
    #1;
    checks++; if (rr_m1.rvalid !== 1'b1) begin errors++; $display("[TB] FAIL vol_m1_rvalid: got %b expected 1", rr_m1.rvalid); end
    checks++; if (rr_m1.rdata !== mem_val(32'h600)) begin errors++; $display("[TB] FAIL vol_m1_rdata: got %h expected %h", rr_m1.rdata, mem_val(32'h600)); end
    checks++; if (rr_m0.rvalid !== 1'b0) begin errors++; $display("[TB] FAIL vol_m0_quiet: got %b expected 0", rr_m0.rvalid); end
    step();
  endtask

  task automatic test_reset_during_read();
    do_reset();
    // m1 locked read accepted.
    m1_valid = 1'b1; m1_lock = 1'b1; m1_addr = 32'h700;
    #1;
    checks++; if (rr_m1.ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_rd_ready: got %b expected 1", rr_m1.ready); end
    step();
    // Reset while m1 issues another read; the first response is out now.
    resetn = 1'b0; m1_addr = 32'h704;
    #1;
    checks++; if (rr_m1.rvalid !== 1'b1) begin errors++; $display("[TB] FAIL rst_first_rvalid: got %b expected 1", rr_m1.rvalid); end
    step();
    // The read issued during reset must not produce a response.
    idle_inputs();
    #1;
    checks++; if (rr_m1.rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_m1_rvalid: got %b expected 0", rr_m1.rvalid); end
    checks++; if (rr_m0.rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_m0_rvalid: got %b expected 0", rr_m0.rvalid); end
    checks++; if (rr_m0.ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_m0_ready: got %b expected 0", rr_m0.ready); end
    checks++; if (rr_m1.ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_m1_ready: got %b expected 0", rr_m1.ready); end
    step();
    // First tie after reset goes to m0; m1's earlier lock is gone.
    resetn = 1'b1;
    m0_valid = 1'b1; m0_addr = 32'h710;
    m1_valid = 1'b1; m1_lock = 1'b1; m1_addr = 32'h720;
    #1;
    checks++; if (rr_m0.ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_tie_m0: got %b expected 1", rr_m0.ready); end
    checks++; if (rr_m1.ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_tie_m1: got %b expected 0", rr_m1.ready); end
    step();
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_single_master();
    test_round_robin();
    test_fixed_priority();
    test_fixed_forced_release();
    test_lock_bound();
    test_voluntary_release();
    test_reset_during_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
